// File: rtl/mux_arb_nto1_pkg.sv
// Shared definitions for the N-to-1 multiplexer/arbiter.
//   MODE_SEL / MODE_RR : values of the mode input (select vs round-robin)
//   NMAX               : largest supported channel count
//   out_state_e        : output-stage state encoding
//   idx_width()        : channel-index width, never less than one bit
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;
    localparam int   NMAX     = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/mux_arb_nto1_rr_arbiter.sv
// Combinational round-robin search.
// Returns the first requesting channel at or after ptr_i+1, wrapping from
// N-1 back to 0.
//   req_i     : request vector, one bit per channel
//   ptr_i     : index of the most recently granted channel
//   gnt_idx_o : winning channel index (0 when gnt_any_o is low)
//   gnt_any_o : at least one channel is requesting
module rr_arbiter #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [SW-1:0] gnt_idx_o,
    output logic          gnt_any_o
);

    localparam logic [SW:0] N_L = (SW+1)'(N);

    logic [SW:0]   sum_v;
    logic [SW-1:0] idx_v;

    // Walk offsets 1..N from the pointer; the first hit wins.
    always_comb begin
        gnt_idx_o = {SW{1'b0}};
        gnt_any_o = 1'b0;
        sum_v     = {(SW+1){1'b0}};
        idx_v     = {SW{1'b0}};
        for (int k = 1; k <= N; k++) begin
            // One extra bit so ptr+k cannot overflow before the wrap.
            sum_v = {1'b0, ptr_i} + (SW+1)'(k);
            if (sum_v >= N_L) begin
                sum_v = sum_v - N_L;
            end else begin
                sum_v = sum_v;
            end
            idx_v = sum_v[SW-1:0];
            if (!gnt_any_o && req_i[idx_v]) begin
                gnt_any_o = 1'b1;
                gnt_idx_o = idx_v;
            end else begin
                gnt_any_o = gnt_any_o;
            end
        end
    end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 multiplexer with select or round-robin arbitration and a single
// registered output stage (EMPTY/FULL) supporting one transfer per cycle.
//   clk_i        : clock, rising edge
//   rst_n_i      : asynchronous active-low reset
//   in_data_i    : channel i data in bits [i*W +: W]
//   in_valid_i   : per-channel valid
//   in_ready_o   : per-channel accept (one-hot or zero)
//   s_i          : channel select used when mode_i = MODE_SEL
//   mode_i       : MODE_SEL or MODE_RR
//   out_o        : registered output data
//   out_valid_o  : out_o holds valid data
//   out_ready_i  : downstream accept
//   grant_o      : index of the channel whose data is in out_o
module mux_arb_nto1
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = idx_width(N)
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic [N*W-1:0] in_data_i,
    input  logic [N-1:0]   in_valid_i,
    output logic [N-1:0]   in_ready_o,
    input  logic [SW-1:0]  s_i,
    input  logic           mode_i,
    output logic [W-1:0]   out_o,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [SW-1:0]  grant_o
);

    localparam logic [SW:0] N_L = (SW+1)'(N);

    out_state_e    state_q, state_d;
    logic [W-1:0]  out_q, out_d;
    logic [SW-1:0] grant_q, grant_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic [W-1:0]  chan_data_s [N];
    logic [SW-1:0] rr_idx_s;
    logic          rr_any_s;
    logic [SW-1:0] cand_idx_s;
    logic          cand_any_s;
    logic          accept_s;
    logic [N-1:0]  in_ready_s;
    logic          xfer_s;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign chan_data_s[g] = in_data_i[g*W +: W];
    end

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_rr (
        .req_i     (in_valid_i),
        .ptr_i     (ptr_q),
        .gnt_idx_o (rr_idx_s),
        .gnt_any_o (rr_any_s)
    );

    // Candidate selection and the one-hot ready vector.
    always_comb begin
        accept_s = (state_q == ST_EMPTY) || out_ready_i;
        if (mode_i == MODE_RR) begin
            cand_idx_s = rr_idx_s;
            cand_any_s = rr_any_s;
        end else begin
            cand_idx_s = s_i;
            // An out-of-range select means no candidate at all.
            cand_any_s = ({1'b0, s_i} < N_L);
        end
        in_ready_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            // Ready is forced low during reset so nothing is consumed then.
            if (rst_n_i && accept_s && cand_any_s && (cand_idx_s == SW'(i))) begin
                in_ready_s[i] = in_valid_i[i];
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    assign xfer_s     = |in_ready_s;
    assign in_ready_o = in_ready_s;

    // Output-stage next state, data/grant capture and pointer update.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_EMPTY: begin
                if (xfer_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer_s) begin
                    state_d = ST_FULL;
                end else if (out_ready_i) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (xfer_s) begin
            out_d   = chan_data_s[cand_idx_s];
            grant_d = cand_idx_s;
        end else begin
            out_d   = out_q;
            grant_d = grant_q;
        end
        // The pointer only tracks round-robin grants; select mode leaves it.
        if (xfer_s && (mode_i == MODE_RR)) begin
            ptr_d = cand_idx_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // State, output and pointer registers; pointer resets to N-1 so
    // channel 0 is searched first.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_EMPTY;
            out_q   <= {W{1'b0}};
            grant_q <= {SW{1'b0}};
            ptr_q   <= SW'(N - 1);
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_o       = out_q;
    assign grant_o     = grant_q;
    assign out_valid_o = (state_q == ST_FULL);

endmodule

// File: doc/mux_arb_nto1.md
MUX_ARB_NTO1 -- requirements
Module: mux_arb_nto1

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of input channels (legal range 2..16).
REQ-002 The block SHALL have parameter W, default 8, meaning the data width per channel.
REQ-003 The block SHALL derive localparam SW = max(1, clog2(N)) as the channel-index width.
REQ-004 Clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 Rst_n  input  1  is the reset: asynchronous, active-low.
REQ-006 In_data  input  N*W  carries channel i data in bits [i*W +: W].
REQ-007 In_valid  input  N  has bit i set when channel i offers data.
REQ-008 In_ready  output  N  has bit i set when channel i data is accepted this cycle.
REQ-009 S  input  SW  is the channel select used in select mode.
REQ-010 Mode  input  1  selects the mode: 0 = select (S-driven), 1 = round-robin.
REQ-011 Out  output  W  is the registered output data.
REQ-012 Out_valid  output  1  is set when Out holds valid data.
REQ-013 Out_ready  input  1  is the downstream accept.
REQ-014 Grant  output  SW  is the index of the channel whose data is in Out.

Function
REQ-015 The output stage SHALL be a two-state FSM: EMPTY (Out_valid=0) and FULL (Out_valid=1).
REQ-016 Define accept = (state==EMPTY) || Out_ready; a transfer on channel i occurs when In_valid[i] && In_ready[i].
REQ-017 In select mode, the candidate SHALL be channel S; if S >= N there SHALL be no candidate.
REQ-018 In round-robin mode, the candidate SHALL be the first channel with In_valid set, searching from ptr+1 upward and wrapping from N-1 to 0.
REQ-019 In_ready SHALL be one-hot or zero; In_ready[c] = accept && In_valid[c] for candidate c; all other bits 0.
REQ-020 On a transfer, Out, Grant and Out_valid SHALL update on the next edge, giving latency of 1 cycle from input transfer to Out_valid.
REQ-021 In FULL with Out_ready=1 and no transfer, the block SHALL go to EMPTY; with a transfer, it SHALL stay FULL with new data, sustaining back-to-back throughput of 1 per cycle.
REQ-022 In FULL with Out_ready=0, Out and Grant SHALL hold stable, and In_ready SHALL be all zero.
REQ-023 ptr SHALL update to the granted index only on a round-robin transfer, and SHALL hold in select mode.
REQ-024 Mode and S are sampled combinationally each cycle; a change of either SHALL never alter data already held in Out.
REQ-025 Simultaneous valid inputs in round-robin mode: under continuous load, every valid channel SHALL be granted within N transfers.

Reset
REQ-026 While Rst_n=0: Out=0, Out_valid=0, Grant=0, ptr=N-1 (so channel 0 has first priority), state=EMPTY.
REQ-027 An assertion of reset mid-transfer SHALL discard held data immediately; In_ready SHALL be 0 while in reset.
REQ-028 Reset deassertion SHALL be taken as synchronised externally; the first transfer is permitted on the first edge after deassertion.

Structure
REQ-029 Package mux_pkg SHALL hold the MODE_SEL=0 and MODE_RR=1 constants and NMAX=16.
REQ-030 Round-robin candidate search SHALL be a sub-module rr_arbiter (parameters N, SW; inputs req and ptr; outputs gnt_idx and gnt_any), purely combinational.
REQ-031 The top level SHALL contain the FSM, ptr register, output registers and select-mode path.

Verification (N=4, W=8)
REQ-032 Mode=0, S=2, In_valid=4'b0100, data ch2=0xA5, Out_ready=1 -> next cycle Out=0xA5, Grant=2, Out_valid=1.
REQ-033 Mode=1, all valid, data chi=0x10+i, Out_ready=1 for 8 cycles -> Grant sequence 0,1,2,3,0,1,2,3.
REQ-034 FULL with Out_ready=0 for 5 cycles -> Out and Grant constant, In_ready=0; then Out_ready=1 -> the next item transfers in that cycle.
REQ-035 Mode=1, only ch3 valid after a ch3 grant -> ch3 is granted again (wrap-around with a single requester).
REQ-036 Mode=0, S=3 with N=3 build -> In_ready=0 and Out_valid stays 0.
REQ-037 Rst_n pulled low while FULL with Out=0x5A -> asynchronously Out=0, Out_valid=0; after release, Mode=1 with all valid grants ch0 first.
